// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester identity, arbiter
// state and the read-response tag carried through the latency pipe.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of read tags matching the memory read latency; the tag
// leaving the last stage lines up with mem_rdata for that read.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] tag_q;
  rd_tag_t [RD_LAT-1:0] tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Clearing every stage drops in-flight reads so no response follows reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the core MEM stage and the
// debug/loader port, and routes read data back to whichever port issued.
//
// state  | meaning
// ARB    | CPU has priority; debug wins when it has waited MAX_WAIT cycles
// LOCKED | debug owns the memory; CPU is refused until dbg_lock drops
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cpu_gnt;
  rd_tag_t           tag_in, tag_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grants are suppressed while reset is held so nothing reaches dmem.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    state_d = state_q;
    if (!reset) begin
      case (state_q)
        ARB: begin
          if (dbg_req && (wait_cnt_q == MAX_WAIT_C)) begin
            dbg_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
          if (dbg_gnt && dbg_lock) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          dbg_gnt = dbg_req;
          if (!dbg_lock) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (dbg_req && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Only reads need a response, so writes enter the pipe as empty slots.
  always_comb begin
    tag_in.valid = mem_en & ~mem_we;
    tag_in.owner = dbg_gnt ? OWN_DBG : OWN_CPU;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    cpu_rvalid = tag_out.valid && (tag_out.owner == OWN_CPU);
    dbg_rvalid = tag_out.valid && (tag_out.owner == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule
